// File: rtl/nx_ctrl_pkg.sv
// Shared types and constants for the Nexus mesh cycle controller.
package nx_ctrl_pkg;
    localparam int OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP   = 2'd0,
        OP_RUN   = 2'd1,
        OP_STOP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_SETTLE,
        ST_WAIT_IDLE,
        ST_CAPTURE
    } ctrl_state_e;
endpackage

// File: rtl/nx_ctrl_watchdog.sv
// Clearable up-counter that stops at a programmable limit and flags it.
module nx_ctrl_watchdog #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_count;

    assign o_expired = (r_count == i_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/nx_mesh_ctrl.sv
// Mesh evaluation sequencer: trigger, settle, wait for all-idle, hand capture slot to host.
//   state      | meaning
//   IDLE       | no run; accepts RUN / CLEAR
//   TRIGGER    | one-clock evaluation pulse to every node
//   SETTLE     | node idle ignored for SETTLE_CYCLES clocks
//   WAIT_IDLE  | waiting for all nodes idle; watchdog running
//   CAPTURE    | outputs stable until host handshake
module nx_mesh_ctrl
    import nx_ctrl_pkg::*;
#(
    parameter int ROWS            = 6,
    parameter int COLUMNS         = 6,
    parameter int CYCLE_WIDTH     = 32,
    parameter int SETTLE_CYCLES   = 2,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    input  logic [OP_WIDTH-1:0]     i_cmd_op,
    input  logic [CYCLE_WIDTH-1:0]  i_cmd_count,
    output logic                    o_cmd_ready,
    output logic                    o_mesh_trigger,
    input  logic [ROWS*COLUMNS-1:0] i_mesh_idle,
    output logic                    o_capture_valid,
    input  logic                    i_capture_ready,
    output logic                    o_active,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [CYCLE_WIDTH-1:0]  o_cycle
);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] LIM_SETTLE = WD_W'(SETTLE_CYCLES - 1);
    localparam logic [WD_W-1:0] LIM_WATCH  = WD_W'(WATCHDOG_CYCLES - 1);

    ctrl_state_e            r_state, w_state_nxt;
    logic [CYCLE_WIDTH-1:0] r_remaining, r_cycle;
    logic                   r_free, r_stop, r_timeout, r_done;
    cmd_op_e                w_op;
    logic                   w_all_idle, w_cmd_ready, w_stop_acc;
    logic                   w_run_load, w_clear, w_cap_fire, w_finish, w_timeout_hit;
    logic                   w_wd_clear, w_wd_en, w_expired;
    logic [WD_W-1:0]        w_wd_limit;

    assign w_op       = cmd_op_e'(i_cmd_op);
    assign w_all_idle = &i_mesh_idle;
    assign w_wd_limit = (r_state == ST_SETTLE) ? LIM_SETTLE : LIM_WATCH;

    // One counter serves both the settle mask and the idle watchdog.
    nx_ctrl_watchdog #(.WIDTH(WD_W)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .i_limit   (w_wd_limit),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_ready   = 1'b0;
        w_stop_acc    = 1'b0;
        w_run_load    = 1'b0;
        w_clear       = 1'b0;
        w_cap_fire    = 1'b0;
        w_finish      = 1'b0;
        w_timeout_hit = 1'b0;
        w_wd_clear    = 1'b0;
        w_wd_en       = 1'b0;
        if (r_state != ST_IDLE) begin
            w_cmd_ready = (w_op == OP_STOP);
            w_stop_acc  = w_cmd_ready && i_cmd_valid;
        end
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (i_cmd_valid && w_op == OP_RUN) begin
                    w_run_load  = 1'b1;
                    w_state_nxt = ST_TRIGGER;
                end
                if (i_cmd_valid && w_op == OP_CLEAR) w_clear = 1'b1;
            end
            ST_TRIGGER: begin
                w_wd_clear  = 1'b1;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_wd_en = 1'b1;
                if (w_expired) begin
                    w_wd_clear  = 1'b1;
                    w_state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                w_wd_en = 1'b1;
                if (w_all_idle) begin
                    w_state_nxt = ST_CAPTURE;
                end else if (w_expired) begin
                    w_timeout_hit = 1'b1;
                    w_finish      = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (i_capture_ready) begin
                    w_cap_fire = 1'b1;
                    if (r_stop || w_stop_acc ||
                        (!r_free && r_remaining == CYCLE_WIDTH'(1))) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_TRIGGER;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_cycle     <= '0;
            r_free      <= 1'b0;
            r_stop      <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_run_load) begin
                r_remaining <= i_cmd_count;
                r_free      <= (i_cmd_count == '0);
                r_stop      <= 1'b0;
            end
            if (w_stop_acc) r_stop <= 1'b1;
            if (w_cap_fire) begin
                r_cycle <= r_cycle + 1'b1;
                if (!r_free) r_remaining <= r_remaining - 1'b1;
            end
            if (w_finish) r_stop <= 1'b0;
            if (w_timeout_hit) r_timeout <= 1'b1;
            if (w_clear) begin
                r_cycle   <= '0;
                r_timeout <= 1'b0;
            end
        end
    end

    assign o_cmd_ready     = w_cmd_ready && !rst;
    assign o_mesh_trigger  = (r_state == ST_TRIGGER);
    assign o_capture_valid = (r_state == ST_CAPTURE);
    assign o_active        = (r_state != ST_IDLE);
    assign o_done          = r_done;
    assign o_timeout       = r_timeout;
    assign o_cycle         = r_cycle;
endmodule

// File: doc/nx_mesh_ctrl.md
Name: nx_mesh_ctrl

Overview:
Simulation-cycle controller for the Nexus logic mesh. It accepts host commands and drives the single mesh-wide evaluation trigger. It waits for every node to report idle, then hands a capture slot to the host so boundary outputs can be read. It also keeps the simulated-cycle count, and a watchdog flags nodes that never settle.

Parameters:
ROWS, 6, mesh rows
COLUMNS, 6, mesh columns
CYCLE_WIDTH, 32, width of cycle counter and run-length field
SETTLE_CYCLES, 2, clocks after trigger during which node idle is ignored (>=1)
WATCHDOG_CYCLES, 1024, clocks allowed in WAIT_IDLE before timeout (>=SETTLE_CYCLES+1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  host command valid
i_cmd_op  in  2  0=NOP, 1=RUN, 2=STOP, 3=CLEAR
i_cmd_count  in  CYCLE_WIDTH  RUN length; 0 = free-run until STOP
o_cmd_ready  out  1  command accepted when valid&ready
o_mesh_trigger  out  1  one-clock evaluation pulse to all nodes
i_mesh_idle  in  ROWS*COLUMNS  per-node idle, bit r*COLUMNS+c
o_capture_valid  out  1  mesh settled, boundary outputs stable
i_capture_ready  in  1  host has sampled outputs
o_active  out  1  run in progress
o_done  out  1  one-clock pulse when a run ends
o_timeout  out  1  sticky watchdog error, cleared by CLEAR or rst
o_cycle  out  CYCLE_WIDTH  completed simulated cycles

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: state IDLE. All outputs are 0, including o_cmd_ready while rst is high. Remaining count and stop latch are cleared. Reset mid-run aborts immediately, with no done pulse.
- States: IDLE, TRIGGER, SETTLE, WAIT_IDLE, CAPTURE.
- IDLE: o_cmd_ready=1.
  - RUN: load remaining=i_cmd_count and free=(count==0), then go to TRIGGER.
  - CLEAR: o_cycle:=0, o_timeout:=0.
  - STOP and NOP: no effect.
- TRIGGER (1 clock): o_mesh_trigger=1, o_active=1. Load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: idle is ignored. Count down; at 0 go to WAIT_IDLE and start the watchdog at 0.
- WAIT_IDLE: leave when &i_mesh_idle is true for one sampled clock, going to CAPTURE.
  - The watchdog increments each clock. When it reaches WATCHDOG_CYCLES, set o_timeout and go to IDLE.
  - On timeout, o_done pulses and o_cycle is not incremented.
- CAPTURE: o_capture_valid=1 until i_capture_ready (can stall indefinitely; no watchdog). On the handshake:
  - o_cycle += 1, wrapping modulo 2^CYCLE_WIDTH.
  - If !free, remaining -= 1.
  - If stop latched, or (!free and remaining==0 after decrement): go to IDLE with o_done=1.
  - Otherwise go to TRIGGER.
  - Back-to-back throughput is therefore 1+SETTLE_CYCLES+1+1 clocks per cycle minimum, when idle is immediate and ready is held.
- While active, o_cmd_ready=1 only when i_cmd_op==STOP. A STOP latches the stop flag, and the current cycle completes including capture. RUN, CLEAR and NOP are not accepted while active.
- STOP accepted on the same clock as the capture handshake ends the run at that handshake.
- o_active=1 in every state except IDLE. o_done is asserted on the same edge IDLE is entered.
- i_mesh_idle may be high before the trigger; SETTLE masking exists for exactly that case.

Decomposition:
- Package nx_ctrl_pkg holds:
  - the command-op enum (NOP/RUN/STOP/CLEAR)
  - the controller state enum
  - the 2-bit op width constant
- Sub-module nx_ctrl_watchdog: a loadable up-counter with a terminal flag, reused for the settle and watchdog counts (parameter WIDTH, ports clk, rst, i_clear, i_enable, i_limit, o_expired).
- The idle AND-reduction stays inline.

Test Plan:
- RUN count=3, i_mesh_idle all-1 from SETTLE end, capture_ready tied 1 -> exactly 3 trigger pulses, 5 clocks apart. o_cycle steps 0→3, o_done pulses once, o_active falls on the same edge.
- RUN count=0, then STOP issued during the 4th WAIT_IDLE -> 4th capture completes. o_cycle=4, no 5th trigger, o_done pulses.
- RUN count=2 with one node idle held 0 -> o_timeout=1 after WATCHDOG_CYCLES clocks in WAIT_IDLE. o_cycle unchanged, state IDLE. A subsequent CLEAR clears o_timeout and o_cycle.
- Capture backpressure: i_capture_ready low for 10 clocks -> o_capture_valid held high, no trigger, o_cycle stable until the handshake, then increments by 1.
- o_cycle preloaded near wrap (run 2^CYCLE_WIDTH-1 cycles at CYCLE_WIDTH=4, then RUN 2) -> o_cycle reads 15 then 0 then 1.
- rst asserted during CAPTURE -> next clock all outputs 0, no o_done. A RUN then starts cleanly, with the first trigger 1 clock after acceptance.
